// File: rtl/mem_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl_if
// Request/response handshake bundle between a requester and mem_req_ctrl.
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = write, 0 = read
//   req_addr/req_wdata    : request address and write data
//   rsp_valid/rsp_ready   : response handshake
//   rsp_write/rsp_err     : echoed request type, out-of-range flag
//   rsp_rdata             : read data (0 for writes and errors)
// The slave modport is the controller's view; master is the requester's.
// ---------------------------------------------------------------------------
interface mem_req_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int REQ_AW = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [REQ_AW-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
// Single-outstanding request controller in front of a small word memory.
// Accepts one read/write request, range-checks the address, sequences the
// memory write/read strobes, captures read data one cycle after the read
// strobe and returns one response, counting completed response handshakes.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus           : request/response handshake (slave modport)
//   mem_addr      : memory word address (latched)
//   mem_wen/ren   : memory write/read strobes, decoded from state
//   mem_wdata     : memory write data (latched)
//   mem_rdata     : memory read data, valid the cycle after mem_ren
//   txn_count     : completed responses, wrapping
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 4,
  parameter int MEM_AW    = 2,
  parameter int REQ_AW    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_ctrl_if.slave     bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              write_q;
  logic              err_q;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              addr_bad;
  logic              rsp_done;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign addr_bad = bus.req_addr >= REQ_AW'(MEM_DEPTH);
  assign rsp_done = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state. An error request skips the memory entirely and responds
  // straight away; reads take an extra cycle for the memory to update.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) begin
                 if (addr_bad)           state_nx = RESP;
                 else if (bus.req_write) state_nx = WR;
                 else                    state_nx = RD;
               end
      WR:      state_nx = RESP;
      RD:      state_nx = RD_WAIT;
      RD_WAIT: state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch and response data. rdata is cleared on acceptance so writes
  // and errors respond with 0; it is only loaded at the end of RD_WAIT, after
  // the memory has updated mem_rdata at the end of RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      err_q   <= addr_bad;
      addr_q  <= bus.req_addr[MEM_AW-1:0];
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (state == RD_WAIT) begin
      rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           cnt_q <= '0;
    else if (rsp_done) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Ready is masked by reset so no request can be accepted on a reset edge.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_write = write_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

  assign mem_wen   = (state == WR);
  assign mem_ren   = (state == RD);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
// Drives two controllers in lockstep (16-bit and 2-bit transaction counters),
// each attached to its own behavioural 4x8 memory that resets to 8'hFF.
// Expected responses come from a word-array model of the memory plus a
// latency/strobe rule table per request kind.
// ---------------------------------------------------------------------------
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr  = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_ready = 1'b1;

  mem_req_ctrl_if #(.DATA_W(8), .REQ_AW(8)) bus1 ();
  mem_req_ctrl_if #(.DATA_W(8), .REQ_AW(8)) bus2 ();

  assign bus1.req_valid = req_valid;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.rsp_ready = rsp_ready;
  assign bus2.req_valid = req_valid;
  assign bus2.req_write = req_write;
  assign bus2.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus2.rsp_ready = rsp_ready;

  logic [1:0]  mem_addr, m2_addr;
  logic        mem_wen, mem_ren, m2_wen, m2_ren;
  logic [7:0]  mem_wdata, mem_rdata, m2_wdata, m2_rdata;
  logic [15:0] txn_count;
  logic [1:0]  txn_count2;

  mem_req_ctrl #(.DATA_W(8), .MEM_DEPTH(4), .MEM_AW(2), .REQ_AW(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus1),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .txn_count(txn_count)
  );

  mem_req_ctrl #(.DATA_W(8), .MEM_DEPTH(4), .MEM_AW(2), .REQ_AW(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .mem_addr(m2_addr), .mem_wen(m2_wen), .mem_ren(m2_ren),
    .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .txn_count(txn_count2)
  );

  // Behavioural memories: read data updates at the edge that samples ren.
  logic [7:0] mem1 [4];
  logic [7:0] mem2 [4];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem1[i] <= 8'hFF;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wen) mem1[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem1[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem2[i] <= 8'hFF;
      m2_rdata <= 8'h00;
    end else begin
      if (m2_wen) mem2[m2_addr] <= m2_wdata;
      if (m2_ren) m2_rdata <= mem2[m2_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] ref_mem [4];
  int         exp_cnt;
  logic       exp_err, exp_write;
  logic [7:0] exp_rdata;
  int         exp_lat, exp_wen, exp_ren;

  // Observations from the last transaction
  bit         obs_timeout, obs_both, obs_stable, obs_ready_hold, obs_cnt_moved;
  int         obs_lat, obs_wen, obs_ren;
  logic [1:0] obs_addr;
  logic [7:0] obs_wdata, obs_rdata;
  logic       obs_err, obs_write, obs_valid_after, obs_ready_after;
  logic [15:0] obs_cnt;
  logic [1:0]  obs_cnt2;

  // Reference: errors respond at once, writes after one strobe cycle,
  // reads after the strobe plus one wait cycle.
  task automatic model_txn(input bit w, input logic [7:0] a, input logic [7:0] d);
    exp_err   = (a >= 8'd4);
    exp_write = w;
    exp_rdata = (exp_err || w) ? 8'h00 : ref_mem[a[1:0]];
    exp_lat   = exp_err ? 0 : (w ? 1 : 2);
    exp_wen   = (!exp_err && w) ? 1 : 0;
    exp_ren   = (!exp_err && !w) ? 1 : 0;
    if (w && !exp_err) ref_mem[a[1:0]] = d;
    exp_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
    exp_cnt = 0;
  endtask

  // Drives one request, records strobe/response behaviour; hold > 0 keeps
  // rsp_ready low for that many cycles while offering a stray request.
  task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input int hold);
    int guard;
    logic [15:0] cnt_before;
    obs_timeout = 0; obs_both = 0; obs_stable = 1; obs_ready_hold = 0;
    obs_cnt_moved = 0; obs_lat = 0; obs_wen = 0; obs_ren = 0;
    obs_addr = '0; obs_wdata = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    rsp_ready = (hold == 0);
    guard = 0;
    while (bus1.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      obs_timeout = 1; req_valid = 1'b0; rsp_ready = 1'b1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_write = ~w;
    guard = 0;
    while (1) begin
      if (mem_wen === 1'b1) begin obs_wen++; obs_addr = mem_addr; obs_wdata = mem_wdata; end
      if (mem_ren === 1'b1) begin obs_ren++; obs_addr = mem_addr; end
      if (mem_wen === 1'b1 && mem_ren === 1'b1) obs_both = 1;
      if (bus1.rsp_valid === 1'b1) break;
      if (guard >= 20) begin
        obs_timeout = 1; rsp_ready = 1'b1;
        return;
      end
      @(negedge clk);
      guard++;
      obs_lat++;
    end
    obs_write = bus1.rsp_write; obs_err = bus1.rsp_err; obs_rdata = bus1.rsp_rdata;
    cnt_before = txn_count;
    if (hold > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 8'h33;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== obs_rdata ||
          bus1.rsp_err !== obs_err || bus1.rsp_write !== obs_write) obs_stable = 0;
      if (bus1.req_ready !== 1'b0) obs_ready_hold = 1;
      if (txn_count !== cnt_before) obs_cnt_moved = 1;
      if (mem_wen !== 1'b0 || mem_ren !== 1'b0) obs_both = 1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    obs_cnt = txn_count; obs_cnt2 = txn_count2;
    obs_valid_after = bus1.rsp_valid; obs_ready_after = bus1.req_ready;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus1.req_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready_low: got %b want 0", bus1.req_ready);
    end
    total++;
    if ({bus1.rsp_valid, bus1.rsp_write, bus1.rsp_err, bus1.rsp_rdata, mem_addr,
         mem_wen, mem_ren, mem_wdata, txn_count} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs: got nonzero want all 0");
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus1.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_ready_after: got %b want 1", bus1.req_ready);
    end
  endtask

  task automatic test_read_after_reset();
    do_reset();
    model_txn(1'b0, 8'd2, 8'h00);
    run_txn(1'b0, 8'd2, 8'h00, 0);
    total++;
    if (obs_timeout || obs_lat != exp_lat) begin
      bad++; $display("[TB] FAIL rar_latency: got %0d (timeout %0d) want %0d", obs_lat, obs_timeout, exp_lat);
    end
    total++;
    if (obs_ren != 1 || obs_wen != 0 || obs_addr !== 2'd2 || obs_both) begin
      bad++; $display("[TB] FAIL rar_strobes: got ren=%0d wen=%0d addr=%0d want ren=1 wen=0 addr=2", obs_ren, obs_wen, obs_addr);
    end
    total++;
    if (obs_rdata !== exp_rdata || obs_err !== 1'b0) begin
      bad++; $display("[TB] FAIL rar_data: got %h err=%b want %h err=0", obs_rdata, obs_err, exp_rdata);
    end
    total++;
    if (obs_cnt !== 16'(exp_cnt) || obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0) begin
      bad++; $display("[TB] FAIL rar_count: got cnt=%0d ready=%b valid=%b want cnt=%0d ready=1 valid=0", obs_cnt, obs_ready_after, obs_valid_after, exp_cnt);
    end
  endtask

  task automatic test_write_read();
    model_txn(1'b1, 8'd1, 8'hA5);
    run_txn(1'b1, 8'd1, 8'hA5, 0);
    total++;
    if (obs_timeout || obs_lat != exp_lat || obs_wen != 1 || obs_ren != 0 ||
        obs_addr !== 2'd1 || obs_wdata !== 8'hA5) begin
      bad++; $display("[TB] FAIL wr_strobe: got lat=%0d wen=%0d ren=%0d addr=%0d wdata=%h want lat=1 wen=1 ren=0 addr=1 wdata=a5", obs_lat, obs_wen, obs_ren, obs_addr, obs_wdata);
    end
    total++;
    if (obs_write !== 1'b1 || obs_rdata !== 8'h00 || obs_err !== 1'b0 || obs_cnt !== 16'(exp_cnt)) begin
      bad++; $display("[TB] FAIL wr_resp: got write=%b rdata=%h err=%b cnt=%0d want 1 00 0 %0d", obs_write, obs_rdata, obs_err, obs_cnt, exp_cnt);
    end
    model_txn(1'b0, 8'd1, 8'h00);
    run_txn(1'b0, 8'd1, 8'h00, 0);
    total++;
    if (obs_rdata !== exp_rdata || obs_write !== 1'b0) begin
      bad++; $display("[TB] FAIL raw_data: got %h write=%b want %h write=0", obs_rdata, obs_write, exp_rdata);
    end
    model_txn(1'b0, 8'd0, 8'h00);
    run_txn(1'b0, 8'd0, 8'h00, 0);
    total++;
    if (obs_rdata !== exp_rdata) begin
      bad++; $display("[TB] FAIL read_other: got %h want %h", obs_rdata, exp_rdata);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] addrs [4];
    bit         wr    [4];
    addrs[0] = 8'h04; wr[0] = 1'b0;
    addrs[1] = 8'h04; wr[1] = 1'b1;
    addrs[2] = 8'hFF; wr[2] = 1'b0;
    addrs[3] = 8'hFF; wr[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model_txn(wr[i], addrs[i], 8'h5C);
      run_txn(wr[i], addrs[i], 8'h5C, 0);
      total++;
      if (obs_timeout || obs_err !== 1'b1 || obs_rdata !== 8'h00 || obs_lat != 0 ||
          obs_wen != 0 || obs_ren != 0 || obs_write !== exp_write) begin
        bad++; $display("[TB] FAIL oor_%0d: got err=%b rdata=%h lat=%0d wen=%0d ren=%0d want err=1 rdata=00 lat=0 no strobes", i, obs_err, obs_rdata, obs_lat, obs_wen, obs_ren);
      end
    end
    for (int a = 0; a < 4; a++) begin
      model_txn(1'b0, 8'(a), 8'h00);
      run_txn(1'b0, 8'(a), 8'h00, 0);
      total++;
      if (obs_rdata !== exp_rdata) begin
        bad++; $display("[TB] FAIL oor_mem_%0d: got %h want %h", a, obs_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_backpressure();
    model_txn(1'b0, 8'd1, 8'h00);
    run_txn(1'b0, 8'd1, 8'h00, 5);
    total++;
    if (obs_timeout || !obs_stable || obs_rdata !== exp_rdata) begin
      bad++; $display("[TB] FAIL bp_stable: got stable=%0d rdata=%h want stable=1 rdata=%h", obs_stable, obs_rdata, exp_rdata);
    end
    total++;
    if (obs_ready_hold || obs_both) begin
      bad++; $display("[TB] FAIL bp_ignore_req: got ready_seen=%0d strobe=%0d want 0 0", obs_ready_hold, obs_both);
    end
    total++;
    if (obs_cnt_moved || obs_cnt !== 16'(exp_cnt)) begin
      bad++; $display("[TB] FAIL bp_count: got moved=%0d cnt=%0d want moved=0 cnt=%0d", obs_cnt_moved, obs_cnt, exp_cnt);
    end
    model_txn(1'b0, 8'd0, 8'h00);
    run_txn(1'b0, 8'd0, 8'h00, 0);
    total++;
    if (obs_rdata !== exp_rdata) begin
      bad++; $display("[TB] FAIL bp_no_stray_write: got %h want %h", obs_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    model_txn(1'b1, 8'd3, 8'h5A);
    run_txn(1'b1, 8'd3, 8'h5A, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus1.rsp_valid, bus1.rsp_write, bus1.rsp_err, bus1.rsp_rdata, mem_addr,
         mem_wen, mem_ren, mem_wdata, txn_count, bus1.req_ready} !== '0) begin
      bad++; $display("[TB] FAIL mid_reset_outputs: got valid=%b write=%b addr=%0d wdata=%h cnt=%0d ready=%b want all 0", bus1.rsp_valid, bus1.rsp_write, mem_addr, mem_wdata, txn_count, bus1.req_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
    exp_cnt = 0;
    #1;
    total++;
    if (bus1.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_reset_ready: got %b want 1", bus1.req_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("[TB] FAIL mid_reset_no_rsp: got %0d response cycles want 0", seen);
    end
    model_txn(1'b0, 8'd3, 8'h00);
    run_txn(1'b0, 8'd3, 8'h00, 0);
    total++;
    if (obs_timeout || obs_rdata !== exp_rdata || obs_cnt !== 16'(exp_cnt)) begin
      bad++; $display("[TB] FAIL mid_reset_next: got rdata=%h cnt=%0d want %h %0d", obs_rdata, obs_cnt, exp_rdata, exp_cnt);
    end
  endtask

  task automatic test_random();
    bit         w;
    logic [7:0] a, d;
    int         hold;
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      d = 8'($urandom);
      hold = $urandom_range(0, 2);
      model_txn(w, a, d);
      run_txn(w, a, d, hold);
      total++;
      if (obs_timeout || obs_lat != exp_lat || obs_wen != exp_wen || obs_ren != exp_ren || obs_both) begin
        bad++; $display("[TB] FAIL rnd_timing_%0d: got lat=%0d wen=%0d ren=%0d want lat=%0d wen=%0d ren=%0d", n, obs_lat, obs_wen, obs_ren, exp_lat, exp_wen, exp_ren);
      end
      total++;
      if (obs_err !== exp_err || obs_write !== exp_write || obs_rdata !== exp_rdata || !obs_stable) begin
        bad++; $display("[TB] FAIL rnd_resp_%0d: got err=%b write=%b rdata=%h want err=%b write=%b rdata=%h", n, obs_err, obs_write, obs_rdata, exp_err, exp_write, exp_rdata);
      end
      total++;
      if ((exp_wen == 1 && (obs_addr !== a[1:0] || obs_wdata !== d)) ||
          (exp_ren == 1 && obs_addr !== a[1:0])) begin
        bad++; $display("[TB] FAIL rnd_bus_%0d: got addr=%0d wdata=%h want addr=%0d wdata=%h", n, obs_addr, obs_wdata, a[1:0], d);
      end
      total++;
      if (obs_cnt !== 16'(exp_cnt) || obs_ready_after !== 1'b1) begin
        bad++; $display("[TB] FAIL rnd_count_%0d: got cnt=%0d ready=%b want cnt=%0d ready=1", n, obs_cnt, obs_ready_after, exp_cnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    bit         w    [5];
    logic [7:0] a    [5];
    w[0] = 1'b1; a[0] = 8'd0;
    w[1] = 1'b0; a[1] = 8'd0;
    w[2] = 1'b1; a[2] = 8'd9;
    w[3] = 1'b0; a[3] = 8'd3;
    w[4] = 1'b1; a[4] = 8'd2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      model_txn(w[i], a[i], 8'(8'h10 + i));
      run_txn(w[i], a[i], 8'(8'h10 + i), 0);
      total++;
      if (obs_timeout || obs_cnt2 !== 2'(exp_cnt % 4)) begin
        bad++; $display("[TB] FAIL wrap_cnt_%0d: got %0d want %0d", i, obs_cnt2, exp_cnt % 4);
      end
    end
    total++;
    if (obs_cnt !== 16'(exp_cnt)) begin
      bad++; $display("[TB] FAIL wrap_wide_cnt: got %0d want %0d", obs_cnt, exp_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
    exp_cnt = 0;
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request controller sitting directly upstream of the 4-entry, 8-bit memory; it is the only driver of that memory's bus. It accepts single read/write requests over a valid/ready handshake, range-checks the address, and sequences the memory's `wen`/`ren` strobes. It captures read data at the correct cycle and returns one response per request over a second valid/ready handshake, with a running transaction count.

## Interface
- `DATA_W`, 8, data width of the request, response and memory bus
- `MEM_DEPTH`, 4, number of memory words; addresses `>= MEM_DEPTH` are errors
- `MEM_AW`, 2, memory address width (`clog2(MEM_DEPTH)`)
- `REQ_AW`, 8, request address width (`>= MEM_AW`)
- `CNT_W`, 16, width of `txn_count`

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  REQ_AW  request address
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_write`  out  1  echo of the request type
- `rsp_err`  out  1  address out of range; no memory access was made
- `rsp_rdata`  out  DATA_W  read data (0 for writes and errors)
- `mem_addr`  out  MEM_AW  memory address
- `mem_wen`  out  1  memory write strobe
- `mem_ren`  out  1  memory read strobe
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; updated by the memory at the edge that samples `mem_ren`=1
- `txn_count`  out  CNT_W  completed response handshakes, modulo 2^CNT_W

## Operation
- **States:** IDLE, WR, RD, RD_WAIT, RESP.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`:
  - Latch write flag, address and data.
  - If `req_addr >= MEM_DEPTH`: go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - Otherwise, a write goes to WR and a read goes to RD.
- **WR:** `mem_wen`=1 for exactly one cycle, then go to RESP with `rsp_err`=0 and `rsp_rdata`=0.
- **RD:** `mem_ren`=1 for exactly one cycle, then go to RD_WAIT.
- **RD_WAIT:** both strobes 0. Capture `mem_rdata` into `rsp_rdata` at the end of this cycle, then go to RESP.
- **RESP:** `rsp_valid`=1, and all `rsp_*` outputs are held stable until `rsp_valid && rsp_ready`. On that handshake, increment `txn_count` (wrapping) and go to IDLE.
- **Strobes and bus outputs:**
  - `mem_wen`/`mem_ren` are decoded from the state register only; they are never asserted together and never asserted for error requests.
  - `mem_addr` = `req_addr[MEM_AW-1:0]` and `mem_wdata` come from the latch and are stable from the cycle after acceptance through RESP.
- **Handshake signals:** `req_ready` = (state == IDLE) && !`rst`. It never depends combinationally on `req_valid`. At most one transaction is outstanding.
- **Reset:** a synchronous reset, including one arriving mid-transaction, forces IDLE and abandons any pending transaction without a response.
  - Reset values: `rsp_valid`, `rsp_write`, `rsp_err`, `rsp_rdata`, `mem_addr`, `mem_wen`, `mem_ren`, `mem_wdata` and `txn_count` are all 0.
  - `req_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.

## Timing
- **Edge numbering:** request accepted at edge E0.
- **Write:**
  - `mem_wen`=1 during cycle E0–E1; the memory writes at E1.
  - `rsp_valid`=1 from E1.
- **Read:**
  - `mem_ren`=1 during E0–E1; the memory updates `mem_rdata` at E1.
  - Capture at E2; `rsp_valid`=1 from E2.
- **Error:** `rsp_valid`=1 from E0.
- **Throughput:**
  - With `rsp_ready` held at 1, a new request can be accepted at the edge after the response handshake.
  - Write = 3 cycles per transaction, read = 4, error = 2.
- **Write-then-read ordering:** the write completes at E1, before any later read can be issued, so a read-after-write to the same address returns the new data.
- **Counter wrap:** `txn_count` wraps from 2^CNT_W−1 to 0.

## Test plan
- **Read after reset:** reset, then read addr 2 → `mem_ren` high exactly 1 cycle with `mem_addr`=2; `rsp_valid` 2 cycles after acceptance with `rsp_rdata`=8'hFF (memory reset value), `rsp_err`=0, `txn_count`=1.
- **Write then read:** write addr 1 = 8'hA5 → `mem_wen` high 1 cycle, `mem_addr`=1, `mem_wdata`=8'hA5, response `rsp_write`=1, `rsp_rdata`=0. Then read addr 1 → `rsp_rdata`=8'hA5; addr 0 still reads 8'hFF.
- **Out-of-range address:** request addr 8'h04 and then 8'hFF (read and write) → `rsp_err`=1, `rsp_rdata`=0, `rsp_valid` the cycle after acceptance; `mem_wen`/`mem_ren` never asserted; memory contents unchanged.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles during a read response → `rsp_valid` and `rsp_rdata` stable; `req_ready`=0 and `req_valid` ignored; `txn_count` increments only on the handshake cycle.
- **Reset mid-transaction:** assert `rst` for 1 cycle while in RD_WAIT → no response produced; the cycle after the reset edge shows all outputs 0 and `txn_count`=0; `req_ready`=1 once `rst` is low, and the next read completes normally.
- **Counter wrap:** with `CNT_W`=2, complete 5 mixed transactions → `txn_count` sequence 1, 2, 3, 0, 1.
